// File: rtl/mem_stage_ls.sv
// mem_stage_ls: pipeline memory stage with branch resolution, SLT/ALU result
// select, and byte/half/word loads and stores against a fixed-latency data
// memory. A three-state sequencer stalls upstream while an access is in flight.
module mem_stage_ls #(
   parameter int DEPTH_WORDS = 1024,
   parameter int MEM_LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_valid,
   input  logic [31:0] i_Address,
   input  logic [31:0] i_WriteData,
   input  logic        i_MemRead,
   input  logic        i_MemWrite,
   input  logic [1:0]  i_Size,
   input  logic        i_Unsigned,
   input  logic        i_branch,
   input  logic [2:0]  i_BranchOp,
   input  logic        i_zero,
   input  logic        i_negative,
   input  logic        i_SLTc,
   output logic        o_PCSrc,
   output logic [31:0] o_Mux,
   output logic [31:0] o_ReadData,
   output logic        o_stall,
   output logic        o_done,
   output logic        o_misaligned
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic           accept, commit, aligned, mem_op;

   // Request captured at acceptance; only the address bits that select a
   // word and a byte lane are kept, the rest wrap.
   logic [AW+1:0]  lat_addr;
   logic [31:0]    lat_wd;
   logic [1:0]     lat_size;
   logic           lat_uns, lat_rd, lat_wr;

   // Request seen by the commit logic: live inputs when committing straight
   // out of IDLE (latency 1), the latched copy otherwise.
   logic [AW+1:0]  cur_addr;
   logic [31:0]    cur_wd;
   logic [1:0]     cur_size;
   logic           cur_uns, cur_rd, cur_wr;

   logic [AW-1:0]  idx;
   logic [3:0]     be;
   logic [31:0]    wdata, rword, rshift, load_val;
   logic [15:0]    rhalf;
   logic           cond;

   // NOTE: the data array has no reset; clearing it would need a per-word
   // sweep and the pipeline never reads a word it has not written.
   logic [31:0]    mem [DEPTH_WORDS];

   assign mem_op = i_MemRead | i_MemWrite;

   // Alignment check on the live request
   always_comb begin
      aligned = 1'b1;
      case (i_Size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~i_Address[0];
         default: aligned = (i_Address[1:0] == 2'b00);
      endcase
   end

   // Next-state, counter and handshake outputs
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned and infers a latch.
      state_nxt    = state;
      cnt_nxt      = cnt;
      accept       = 1'b0;
      commit       = 1'b0;
      o_stall      = 1'b0;
      o_done       = 1'b0;
      o_misaligned = 1'b0;
      case (state)
         IDLE: begin
            if (i_valid && mem_op) begin
               if (aligned) begin
                  accept  = 1'b1;
                  o_stall = 1'b1;
                  cnt_nxt = 4'(MEM_LATENCY - 1);
                  if (MEM_LATENCY > 1) begin
                     state_nxt = BUSY;
                  end else begin
                     state_nxt = DONE;
                     commit    = 1'b1;
                  end
               end else begin
                  o_misaligned = 1'b1;
               end
            end
         end
         BUSY: begin
            o_stall = 1'b1;
            cnt_nxt = cnt - 4'd1;
            // Counter reaches zero on this edge: access commits entering DONE.
            if (cnt <= 4'd1) begin
               state_nxt = DONE;
               commit    = 1'b1;
            end
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and latency counter
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      if (i_reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Capture the request so upstream changes during BUSY have no effect
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         lat_addr <= '0;
         lat_wd   <= '0;
         lat_size <= 2'b00;
         lat_uns  <= 1'b0;
         lat_rd   <= 1'b0;
         lat_wr   <= 1'b0;
      end else if (accept) begin
         lat_addr <= i_Address[AW+1:0];
         lat_wd   <= i_WriteData;
         lat_size <= i_Size;
         lat_uns  <= i_Unsigned;
         lat_rd   <= i_MemRead;
         lat_wr   <= i_MemWrite;
      end
   end

   // Request source, byte enables, lane-replicated store data, load extract
   always_comb begin
      if (state == IDLE) begin
         cur_addr = i_Address[AW+1:0];
         cur_wd   = i_WriteData;
         cur_size = i_Size;
         cur_uns  = i_Unsigned;
         cur_rd   = i_MemRead;
         cur_wr   = i_MemWrite;
      end else begin
         cur_addr = lat_addr;
         cur_wd   = lat_wd;
         cur_size = lat_size;
         cur_uns  = lat_uns;
         cur_rd   = lat_rd;
         cur_wr   = lat_wr;
      end
      idx    = cur_addr[AW+1:2];
      rword  = mem[idx];
      rshift = rword >> {cur_addr[1:0], 3'b000};
      rhalf  = cur_addr[1] ? rword[31:16] : rword[15:0];
      case (cur_size)
         2'b00: begin
            be       = 4'b0001 << cur_addr[1:0];
            wdata    = {4{cur_wd[7:0]}};
            load_val = cur_uns ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
         end
         2'b01: begin
            be       = cur_addr[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{cur_wd[15:0]}};
            load_val = cur_uns ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
         end
         default: begin
            be       = 4'b1111;
            wdata    = cur_wd;
            load_val = rword;
         end
      endcase
   end

   // Byte-enabled store at commit; reset on the same edge drops it
   always_ff @(posedge i_clk) begin
      if (commit && cur_wr && !i_reset) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Load result register, held until the next load commits
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_ReadData <= 32'd0;
      end else if (commit && cur_rd) begin
         o_ReadData <= load_val;
      end
   end

   // Branch condition and result select, independent of the sequencer
   always_comb begin
      case (i_BranchOp)
         3'b000:  cond = i_zero;
         3'b001:  cond = ~i_zero;
         3'b100:  cond = i_negative;
         3'b101:  cond = ~i_negative;
         default: cond = 1'b0;
      endcase
      o_PCSrc = i_valid & i_branch & cond;
      o_Mux   = i_SLTc ? {31'b0, i_negative} : i_Address;
   end

endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: three instances (latency 1, 4, 3) driven one at a time.
// Stimulus pushes expected completions into a scoreboard queue; a monitor
// pops and compares whenever an instance pulses o_done.
module tb_mem_stage_ls;

   localparam int LATS [3] = '{1, 4, 3};

   typedef struct {
      int          g;
      bit          is_load;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rst_s, valid_s, rd_s, wr_s, uns_s, br_s, zero_s, neg_s, slt_s;
   logic [31:0] addr_s [3];
   logic [31:0] wd_s   [3];
   logic [1:0]  size_s [3];
   logic [2:0]  bop_s  [3];
   logic [2:0]  pcsrc_s, stall_s, done_s, mis_s;
   logic [31:0] mux_s  [3];
   logic [31:0] rdata_s[3];

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_stage_ls #(.DEPTH_WORDS(64), .MEM_LATENCY(LATS[g])) dut (
         .i_clk       (clk),
         .i_reset     (rst_s[g]),
         .i_valid     (valid_s[g]),
         .i_Address   (addr_s[g]),
         .i_WriteData (wd_s[g]),
         .i_MemRead   (rd_s[g]),
         .i_MemWrite  (wr_s[g]),
         .i_Size      (size_s[g]),
         .i_Unsigned  (uns_s[g]),
         .i_branch    (br_s[g]),
         .i_BranchOp  (bop_s[g]),
         .i_zero      (zero_s[g]),
         .i_negative  (neg_s[g]),
         .i_SLTc      (slt_s[g]),
         .o_PCSrc     (pcsrc_s[g]),
         .o_Mux       (mux_s[g]),
         .o_ReadData  (rdata_s[g]),
         .o_stall     (stall_s[g]),
         .o_done      (done_s[g]),
         .o_misaligned(mis_s[g])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_idle(input int g);
      valid_s[g] = 1'b0; rd_s[g] = 1'b0; wr_s[g] = 1'b0; uns_s[g] = 1'b0;
      br_s[g] = 1'b0; zero_s[g] = 1'b0; neg_s[g] = 1'b0; slt_s[g] = 1'b0;
      addr_s[g] = '0; wd_s[g] = '0; size_s[g] = 2'b00; bop_s[g] = 3'b000;
   endtask

   // Issue one aligned access at posedge+1 and hold it until o_done.
   task automatic do_op(input int g, input bit rd, input bit wr, input logic [1:0] sz,
                        input bit uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit toggle);
      int stall_cnt = 0;
      int done_at   = -1;
      exp_t e;
      e.g = g; e.is_load = rd; e.data = exp_rd;
      sb_q.push_back(e);
      valid_s[g] = 1'b1; rd_s[g] = rd; wr_s[g] = wr; size_s[g] = sz;
      uns_s[g] = uns; addr_s[g] = a; wd_s[g] = wd;
      for (int c = 0; c < LATS[g] + 3 && done_at < 0; c++) begin
         @(negedge clk);
         if (stall_s[g]) stall_cnt++;
         if (done_s[g]) done_at = c;
         @(posedge clk); #1;
         if (toggle && done_at < 0) begin
            addr_s[g] = a ^ 32'h18; size_s[g] = 2'b00; uns_s[g] = ~uns;
            wd_s[g] = ~wd;
         end
      end
      set_idle(g);
      check("stall_cycles", stall_cnt, LATS[g]);
      check("done_cycle", done_at, LATS[g]);
   endtask

   task automatic misaligned_op(input int g, input logic [1:0] sz, input logic [31:0] a);
      valid_s[g] = 1'b1; rd_s[g] = 1'b1; size_s[g] = sz; addr_s[g] = a;
      @(negedge clk);
      check("mis_flag", mis_s[g], 1'b1);
      check("mis_stall", stall_s[g], 1'b0);
      @(posedge clk); #1;
      set_idle(g);
      @(negedge clk);
      check("mis_no_done", done_s[g], 1'b0);
      @(posedge clk); #1;
   endtask

   // Monitor: every o_done pulse must match the head of the scoreboard
   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (!rst_s[g] && done_s[g]) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", {29'd0, 3'(g)}, 32'hFFFFFFFF);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_inst", g, e.g);
               if (e.is_load) check("sb_rdata", rdata_s[g], e.data);
            end
         end
      end
   end

   function automatic bit br_model(input logic [2:0] op, input bit z, input bit n);
      case (op)
         3'b000:  return z;
         3'b001:  return !z;
         3'b100:  return n;
         3'b101:  return !n;
         default: return 1'b0;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] ops [5];
      ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
      rst_s = 3'b111;
      for (int g = 0; g < 3; g++) set_idle(g);
      repeat (3) @(posedge clk);
      #1 rst_s = 3'b000;

      // Reset state
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check("rst_rdata", rdata_s[g], 32'd0);
         check("rst_done", done_s[g], 1'b0);
         check("rst_stall", stall_s[g], 1'b0);
         check("rst_mis", mis_s[g], 1'b0);
         check("rst_pcsrc", pcsrc_s[g], 1'b0);
         check("rst_mux", mux_s[g], 32'd0);
      end
      @(posedge clk); #1;

      // Latency 1: word store/load
      do_op(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      do_op(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

      // Byte/half extension from 0x80FF7F01 @0x20
      do_op(0, 0, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 32'h0, 0);
      do_op(0, 1, 0, 2'b00, 0, 32'h22, 32'h0, 32'hFFFFFFFF, 0);
      do_op(0, 1, 0, 2'b00, 1, 32'h23, 32'h0, 32'h00000080, 0);
      do_op(0, 1, 0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFF80FF, 0);
      do_op(0, 1, 0, 2'b01, 1, 32'h20, 32'h0, 32'h00007F01, 0);

      // Store lanes
      do_op(0, 0, 1, 2'b10, 0, 32'h30, 32'h11223344, 32'h0, 0);
      do_op(0, 0, 1, 2'b00, 0, 32'h31, 32'h000000AA, 32'h0, 0);
      do_op(0, 1, 0, 2'b10, 0, 32'h30, 32'h0, 32'h1122AA44, 0);
      do_op(0, 0, 1, 2'b01, 0, 32'h32, 32'h0000BEEF, 32'h0, 0);
      do_op(0, 1, 0, 2'b10, 0, 32'h30, 32'h0, 32'hBEEFAA44, 0);

      // Misaligned accesses leave memory and o_ReadData untouched
      do_op(0, 0, 1, 2'b10, 0, 32'h40, 32'h55667788, 32'h0, 0);
      wr_s[0] = 1'b0; wd_s[0] = 32'hFFFFFFFF;
      misaligned_op(0, 2'b10, 32'h41);
      misaligned_op(0, 2'b01, 32'h43);
      check("mis_rdata_hold", rdata_s[0], 32'hBEEFAA44);
      valid_s[0] = 1'b1; wr_s[0] = 1'b1; size_s[0] = 2'b10;
      addr_s[0] = 32'h42; wd_s[0] = 32'hFFFFFFFF;
      @(negedge clk);
      check("mis_store_flag", mis_s[0], 1'b1);
      @(posedge clk); #1;
      set_idle(0);
      do_op(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h55667788, 0);

      // Branch resolution over every op/flag/valid combination
      for (int o = 0; o < 5; o++) begin
         for (int f = 0; f < 8; f++) begin
            @(negedge clk);
            bop_s[0] = ops[o]; zero_s[0] = f[0]; neg_s[0] = f[1];
            valid_s[0] = f[2]; br_s[0] = 1'b1;
            #1 check($sformatf("pcsrc_op%0d_f%0d", o, f), pcsrc_s[0],
                     f[2] & br_model(ops[o], f[0], f[1]));
         end
      end
      @(negedge clk);
      bop_s[0] = 3'b000; zero_s[0] = 1'b1; valid_s[0] = 1'b1; br_s[0] = 1'b0;
      #1 check("pcsrc_no_branch", pcsrc_s[0], 1'b0);

      // Result select and zero-latency non-memory instruction
      @(negedge clk);
      set_idle(0);
      valid_s[0] = 1'b1; addr_s[0] = 32'h12345678; neg_s[0] = 1'b1; slt_s[0] = 1'b1;
      #1 check("mux_slt", mux_s[0], 32'd1);
      check("nonmem_stall", stall_s[0], 1'b0);
      slt_s[0] = 1'b0;
      #1 check("mux_alu", mux_s[0], 32'h12345678);
      @(posedge clk); #1;
      set_idle(0);

      // Latency 4: inputs toggled during BUSY, back-to-back loads
      do_op(1, 0, 1, 2'b10, 0, 32'h08, 32'hCAFEF00D, 32'h0, 0);
      do_op(1, 0, 1, 2'b10, 0, 32'h10, 32'h12345678, 32'h0, 0);
      do_op(1, 1, 0, 2'b10, 0, 32'h08, 32'h0, 32'hCAFEF00D, 1);
      do_op(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h12345678, 0);

      // Latency 3: reset in the second BUSY cycle of a store
      do_op(2, 0, 1, 2'b10, 0, 32'h04, 32'h0BADF00D, 32'h0, 0);
      do_op(2, 1, 0, 2'b10, 0, 32'h04, 32'h0, 32'h0BADF00D, 0);
      valid_s[2] = 1'b1; wr_s[2] = 1'b1; size_s[2] = 2'b10;
      addr_s[2] = 32'h04; wd_s[2] = 32'hFFFFFFFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_s[2] = 1'b1;
      @(negedge clk);
      check("pre_rst_stall", stall_s[2], 1'b1);
      @(posedge clk); #1;
      rst_s[2] = 1'b0;
      set_idle(2);
      @(negedge clk);
      check("post_rst_stall", stall_s[2], 1'b0);
      check("post_rst_done", done_s[2], 1'b0);
      check("post_rst_rdata", rdata_s[2], 32'd0);
      @(posedge clk); #1;
      do_op(2, 1, 0, 2'b10, 0, 32'h04, 32'h0, 32'h0BADF00D, 0);

      repeat (3) @(posedge clk);
      check("sb_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage_ls.md
# mem_stage_ls

Parametrised successor to the pipeline memory stage. It resolves conditional branches and selects the SLT/ALU result, as before. It adds byte, halfword and word loads and stores with sign/zero extension and misalignment detection. Data memory has a configurable access latency, sequenced by a small FSM that stalls the pipeline through a stall/done handshake. It sits between the EX/MEM and MEM/WB pipeline registers.

## Interface
- DEPTH_WORDS, 1024: data memory depth in 32-bit words, power of two; word index = i_Address[log2(DEPTH_WORDS)+1:2], upper bits ignored (wrap)
- MEM_LATENCY, 1: cycles from acceptance to commit, range 1..15
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  instruction present in stage
- i_Address  in  32  ALU result / effective address
- i_WriteData  in  32  store data, lane 0 aligned
- i_MemRead  in  1  load
- i_MemWrite  in  1  store (MemRead and MemWrite never both 1)
- i_Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- i_Unsigned  in  1  zero-extend loads when 1
- i_branch  in  1  branch instruction
- i_BranchOp  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, others never taken
- i_zero, i_negative  in  1 each  ALU flags
- i_SLTc  in  1  select SLT result on o_Mux
- o_PCSrc  out  1  branch taken
- o_Mux  out  32  i_SLTc ? {31'b0, i_negative} : i_Address
- o_ReadData  out  32  extended load result, registered
- o_stall  out  1  hold upstream pipeline registers
- o_done  out  1  one-cycle pulse, memory access finished
- o_misaligned  out  1  misaligned access rejected this cycle

## Operation
- Branch: cond = zero (BEQ), !zero (BNE), negative (BLT), !negative (BGE); o_PCSrc = i_valid & i_branch & cond; combinational; o_PCSrc is computed the same way in every FSM state.
- o_Mux: combinational, independent of FSM.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0. In IDLE with i_valid and a memory op, o_misaligned=1 that cycle. No access, no stall, memory unchanged, o_done stays 0.
- FSM states IDLE, BUSY, DONE; 4-bit down-counter cnt.
- IDLE: accept when i_valid & (MemRead|MemWrite) & aligned. Latch address, write data, size, unsigned and op. Set cnt=MEM_LATENCY-1. Go to BUSY if MEM_LATENCY>1, else DONE.
- BUSY: cnt decrements. On the edge where cnt==0, go to DONE.
- Commit: on the edge entering DONE, perform the access. A store writes byte lanes selected by addr[1:0]/size, using byte enables. A byte store replicates WriteData[7:0] into the addressed lane; a half store writes WriteData[15:0] into lanes {1:0} or {3:2}. A load captures the addressed lane(s), extended per i_Unsigned, into o_ReadData.
- DONE: o_done=1 for exactly one cycle. i_valid is ignored because upstream still holds the completed instruction. Go to IDLE.
- o_stall = (IDLE & accept) | BUSY; combinational from inputs in the accept cycle.
- o_ReadData holds its last load value until the next load commits; stores do not alter it.
- Memory contents are not initialised by reset.

## Timing
- Reset values: state IDLE, cnt 0, o_ReadData 0, o_done 0, o_stall 0, o_misaligned 0. o_PCSrc and o_Mux are combinational (0 when inputs are 0).
- Access accepted in cycle T. o_stall=1 in cycles T..T+MEM_LATENCY-1. Commit on the edge ending T+MEM_LATENCY-1. o_done=1 and valid o_ReadData in T+MEM_LATENCY, with o_stall=0.
- Each access occupies MEM_LATENCY+1 cycles. A back-to-back memory op is accepted at T+MEM_LATENCY+1, not earlier.
- Non-memory instructions in IDLE: zero added latency, o_stall=0.
- Reset in any state: returns to IDLE next edge. A pending store is dropped (memory unchanged) and a pending load leaves o_ReadData=0. Reset wins over a commit on the same edge.
- Input changes during BUSY have no effect on the latched request.

## Test plan
- MEM_LATENCY=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> o_stall 1 for 1 cycle each, o_done at T+1, o_ReadData=0xDEADBEEF.
- Byte/half extension: memory word @0x20=0x80FF7F01. LB @0x22 -> 0xFFFFFFFF; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
- Store lanes: SB 0xAA @0x31 over 0x11223344 -> word 0x1122AA44; SH 0xBEEF @0x32 -> 0xBEEFAA44.
- MEM_LATENCY=4: load -> o_stall high exactly 4 cycles, o_done pulse at T+4. Inputs are toggled during BUSY and the result reflects the latched address. The next load is accepted at T+5.
- Misaligned LW @0x41 and LH @0x43 -> o_misaligned=1, o_stall=0, no o_done, memory unchanged. BEQ/BNE/BLT/BGE cover all zero/negative combos with and without i_valid; o_PCSrc matches the condition only when i_valid & i_branch.
- Assert i_reset in the second BUSY cycle of a store (MEM_LATENCY=3) -> IDLE next cycle, o_stall 0, readback shows the old contents, no o_done pulse.
